// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: arbitrates icache/dcache onto one tagged memory port and
// routes each tagged completion back to its owner with the original address.
module mem_req_scheduler #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      icache_command,
  input  logic [XLEN-1:0] icache_addr,
  output logic            icache_grant,
  input  logic [1:0]      dcache_command,
  input  logic [XLEN-1:0] dcache_addr,
  input  logic [63:0]     dcache_data,
  output logic            dcache_grant,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            resp_valid,
  output logic            resp_which,
  output logic [63:0]     resp_data,
  output logic [XLEN-1:0] resp_addr,
  output logic [3:0]      outstanding_count,
  output logic            spurious_tag
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;
  localparam logic [3:0] MAX_OUT    = 4'(MAX_OUTSTANDING);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [15:0]     r_valid;
  logic            r_owner [16];
  logic [XLEN-1:0] r_addr  [16];
  logic [3:0]      r_count;
  logic [7:0]      r_starve;
  logic            r_spurious;

  logic        w_i_req, w_d_load, w_d_store, w_load_ok, w_i_elig, w_d_elig;
  logic        w_sel_i, w_sel_d, w_acc, w_alloc, w_hit, w_unknown, w_clash, w_inc;
  logic [15:0] w_valid_next;

  // an icache store is illegal and simply never requests
  assign w_i_req   = icache_command == BUS_LOAD;
  assign w_d_load  = dcache_command == BUS_LOAD;
  assign w_d_store = dcache_command == BUS_STORE;
  assign w_load_ok = r_count < MAX_OUT;
  assign w_i_elig  = !reset && w_i_req && w_load_ok;
  assign w_d_elig  = !reset && (w_d_store || (w_d_load && w_load_ok));
  assign w_sel_i   = w_i_elig && (r_starve == STARVE_MAX || !w_d_elig);
  assign w_sel_d   = w_d_elig && !w_sel_i;
  assign w_acc     = |mem2proc_response;

  assign icache_grant     = w_sel_i && w_acc;
  assign dcache_grant     = w_sel_d && w_acc;
  assign proc2mem_command = w_sel_i ? BUS_LOAD : w_sel_d ? dcache_command : BUS_NONE;
  assign proc2mem_addr    = w_sel_i ? icache_addr : w_sel_d ? dcache_addr : '0;
  assign proc2mem_data    = (w_sel_d && w_d_store) ? dcache_data : '0;

  assign w_alloc   = (icache_grant || dcache_grant) && proc2mem_command == BUS_LOAD;
  assign w_hit     = !reset && |mem2proc_tag && r_valid[mem2proc_tag];
  assign w_unknown = |mem2proc_tag && !r_valid[mem2proc_tag];
  // a live entry being re-granted is an overwrite, unless it retires this same cycle
  assign w_clash   = r_valid[mem2proc_response] && !(w_hit && mem2proc_tag == mem2proc_response);
  assign w_inc     = w_alloc && !w_clash;

  assign resp_valid        = w_hit;
  assign resp_which        = r_owner[mem2proc_tag];
  assign resp_addr         = r_addr[mem2proc_tag];
  assign resp_data         = mem2proc_data;
  assign outstanding_count = r_count;
  assign spurious_tag      = r_spurious;

  always_comb begin
    w_valid_next = r_valid;
    if (w_hit) w_valid_next[mem2proc_tag] = 1'b0;
    if (w_alloc) w_valid_next[mem2proc_response] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_spurious <= 1'b0;
    end else begin
      r_valid    <= w_valid_next;
      r_count    <= r_count + 4'(w_inc) - 4'(w_hit);
      r_starve   <= (w_i_req && !icache_grant) ? ((r_starve == STARVE_MAX) ? r_starve : r_starve + 8'd1) : '0;
      r_spurious <= r_spurious || w_unknown || (w_alloc && w_clash);
    end
  end

  always_ff @(posedge clock) begin
    if (w_alloc) begin
      r_owner[mem2proc_response] <= dcache_grant ? DCACHE : ICACHE;
      r_addr[mem2proc_response]  <= proc2mem_addr;
    end
  end
endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb_mem_req_scheduler: directed checks of arbitration, tag tracking, limits and reset.
module tb_mem_req_scheduler;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache_command, dcache_command, proc2mem_command;
  logic [31:0] icache_addr, dcache_addr, proc2mem_addr, resp_addr;
  logic [63:0] dcache_data, proc2mem_data, mem2proc_data, resp_data;
  logic [3:0]  mem2proc_response, mem2proc_tag, outstanding_count;
  logic        icache_grant, dcache_grant, resp_valid, resp_which, spurious_tag;
  int checks = 0;
  int errors = 0;

  mem_req_scheduler dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr), .icache_grant(icache_grant),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .dcache_grant(dcache_grant),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .resp_valid(resp_valid), .resp_which(resp_which), .resp_data(resp_data), .resp_addr(resp_addr),
    .outstanding_count(outstanding_count), .spurious_tag(spurious_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    icache_command = 2'd0; icache_addr = '0;
    dcache_command = 2'd0; dcache_addr = '0; dcache_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    icache_command = 2'd1; dcache_command = 2'd1; mem2proc_response = 4'd1;
    #2;
    chk("rst_count", outstanding_count, 0);
    chk("rst_spur", spurious_tag, 0);
    chk("rst_igrant", icache_grant, 0);
    chk("rst_dgrant", dcache_grant, 0);
    chk("rst_cmd", proc2mem_command, 0);
    nxt(); reset = 1'b0; idle();
    // both load: dcache wins with tag 1, icache follows with tag 2
    nxt();
    icache_command = 2'd1; icache_addr = 32'd111;
    dcache_command = 2'd1; dcache_addr = 32'd222; mem2proc_response = 4'd1;
    #1;
    chk("both_dgrant", dcache_grant, 1);
    chk("both_igrant", icache_grant, 0);
    chk("both_addr", proc2mem_addr, 222);
    chk("both_cmd", proc2mem_command, 1);
    nxt(); dcache_command = 2'd0; mem2proc_response = 4'd2;
    #1;
    chk("i_follow_grant", icache_grant, 1);
    chk("i_follow_addr", proc2mem_addr, 111);
    chk("count1", outstanding_count, 1);
    // rejection: nothing recorded
    nxt(); idle(); dcache_command = 2'd1; dcache_addr = 32'h999;
    #1;
    chk("rej_grant", dcache_grant, 0);
    chk("rej_cmd", proc2mem_command, 1);
    chk("count2", outstanding_count, 2);
    nxt(); idle(); mem2proc_tag = 4'd1; mem2proc_data = 64'hDEAD;
    #1;
    chk("rej_count", outstanding_count, 2);
    chk("c1_valid", resp_valid, 1);
    chk("c1_which", resp_which, 1);
    chk("c1_addr", resp_addr, 222);
    chk("c1_data", resp_data, 64'hDEAD);
    nxt(); mem2proc_tag = 4'd2;
    #1;
    chk("c2_count", outstanding_count, 1);
    chk("c2_which", resp_which, 0);
    chk("c2_addr", resp_addr, 111);
    nxt(); idle();
    #1;
    chk("count0", outstanding_count, 0);
    // starvation: dcache wins four times, icache forced on the fifth
    for (int i = 0; i < 4; i++) begin
      nxt();
      icache_command = 2'd1; icache_addr = 32'h111;
      dcache_command = 2'd1; dcache_addr = 32'h300 + i; mem2proc_response = 4'(i + 1);
      #1;
      chk("starve_dgrant", dcache_grant, 1);
      chk("starve_igrant", icache_grant, 0);
    end
    nxt(); dcache_addr = 32'h304; mem2proc_response = 4'd5;
    #1;
    chk("forced_igrant", icache_grant, 1);
    chk("forced_dgrant", dcache_grant, 0);
    chk("forced_addr", proc2mem_addr, 32'h111);
    nxt(); idle(); mem2proc_tag = 4'd5;
    #1;
    chk("count5", outstanding_count, 5);
    chk("c5_which", resp_which, 0);
    chk("c5_addr", resp_addr, 32'h111);
    for (int k = 1; k <= 4; k++) begin
      nxt(); mem2proc_tag = 4'(k);
      #1;
      chk("drain_addr", resp_addr, 32'h300 + k - 1);
    end
    nxt(); idle();
    #1;
    chk("drain_count", outstanding_count, 0);
    // fill to the load limit
    for (int i = 1; i <= 8; i++) begin
      nxt(); dcache_command = 2'd1; dcache_addr = 32'h3FF + i; mem2proc_response = 4'(i);
      #1;
      chk("fill_grant", dcache_grant, 1);
    end
    nxt();
    dcache_addr = 32'h4FF; icache_command = 2'd1; icache_addr = 32'h111; mem2proc_response = 4'd9;
    #1;
    chk("full_count", outstanding_count, 8);
    chk("full_cmd", proc2mem_command, 0);
    chk("full_dgrant", dcache_grant, 0);
    chk("full_igrant", icache_grant, 0);
    chk("full_addr", proc2mem_addr, 0);
    nxt(); dcache_command = 2'd2; dcache_addr = 32'h500; dcache_data = 64'hCAFE;
    #1;
    chk("st_cmd", proc2mem_command, 2);
    chk("st_grant", dcache_grant, 1);
    chk("st_data", proc2mem_data, 64'hCAFE);
    chk("st_addr", proc2mem_addr, 32'h500);
    nxt(); idle(); mem2proc_tag = 4'd8;
    #1;
    chk("st_count", outstanding_count, 8);
    chk("c8_valid", resp_valid, 1);
    // completion and re-grant of tag 3 in the same cycle
    nxt(); idle();
    icache_command = 2'd1; icache_addr = 32'h700; mem2proc_response = 4'd3;
    mem2proc_tag = 4'd3; mem2proc_data = 64'hBEEF;
    #1;
    chk("same_count_pre", outstanding_count, 7);
    chk("same_valid", resp_valid, 1);
    chk("same_which", resp_which, 1);
    chk("same_addr", resp_addr, 32'h402);
    chk("same_data", resp_data, 64'hBEEF);
    chk("same_igrant", icache_grant, 1);
    nxt(); idle(); mem2proc_tag = 4'd3;
    #1;
    chk("same_count", outstanding_count, 7);
    chk("same_spur", spurious_tag, 0);
    chk("new3_which", resp_which, 0);
    chk("new3_addr", resp_addr, 32'h700);
    // unknown tag sets the sticky flag
    nxt(); idle(); mem2proc_tag = 4'd9;
    #1;
    chk("t9_count", outstanding_count, 6);
    chk("t9_valid", resp_valid, 0);
    nxt(); idle();
    #1;
    chk("spur_set", spurious_tag, 1);
    nxt(); mem2proc_tag = 4'd1; dcache_command = 2'd1; dcache_addr = 32'h800; mem2proc_response = 4'd4;
    #1;
    chk("spur_held", spurious_tag, 1);
    chk("pre_rst_valid", resp_valid, 1);
    chk("pre_rst_grant", dcache_grant, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_count", outstanding_count, 0);
    chk("mid_rst_grant", dcache_grant, 0);
    chk("mid_rst_cmd", proc2mem_command, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_spur", spurious_tag, 0);
    nxt(); reset = 1'b0; idle();
    #1;
    chk("post_rst_count", outstanding_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
